counter: RTL and testbench

- Parameterised up-counter with enable, counting from 0 to MAX_COUNTER_VALUE.
- On reaching the terminal value it saturates and flags completion on finished_o.
- Used as a generic timing/sequencing primitive: a controller raises enable_i for the duration of the operation and watches finished_o.
- Single clock domain, synchronous active-high reset.

---
 rtl/counter_pkg.sv | 13 +
 rtl/counter.sv | 43 ++++
 tb/tb_counter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared sizing helper for the counter primitive.
`default_nettype none

package counter_pkg;

  // Number of bits needed to hold every value in 0..max_value.
  function automatic int count_width(input int max_value);
    return $clog2(max_value + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter.sv
// Saturating up-counter with level-sensitive enable; flags completion at MAX.
`default_nettype none

module counter
  import counter_pkg::*;
#(
  parameter int MAX_COUNTER_VALUE = 160,
  localparam int W = count_width(MAX_COUNTER_VALUE)
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         enable_i,
  output logic         finished_o,
  output logic [W-1:0] counter_val_o
);

  localparam logic [W-1:0] MAX_VAL = W'(MAX_COUNTER_VALUE);
  localparam logic [W-1:0] ONE     = W'(1);

  if (MAX_COUNTER_VALUE < 1) begin : g_bad_max
    $fatal(1, "counter: MAX_COUNTER_VALUE must be >= 1");
  end

  logic [W-1:0] count;
  logic         at_max;

  assign at_max = (count == MAX_VAL);

  // Saturate at MAX so the register can never wrap or overflow W.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count <= '0;
    end else if (enable_i && !at_max) begin
      count <= count + ONE;
    end
  end

  assign counter_val_o = count;
  assign finished_o    = at_max;

endmodule

`default_nettype wire

// File: tb/tb_counter.sv
// Directed self-checking bench for counter (MAX = 160, 1 and 3).
`default_nettype none

module tb_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en;
  logic       fin;
  logic [7:0] val;

  logic       rst_s, en_s;
  logic       fin1, fin3;
  logic       val1;
  logic [1:0] val3;

  int checks   = 0;
  int failures = 0;

  counter #(.MAX_COUNTER_VALUE(160)) dut (
    .clock_i(clk), .reset_i(rst), .enable_i(en),
    .finished_o(fin), .counter_val_o(val)
  );

  counter #(.MAX_COUNTER_VALUE(1)) dut1 (
    .clock_i(clk), .reset_i(rst_s), .enable_i(en_s),
    .finished_o(fin1), .counter_val_o(val1)
  );

  counter #(.MAX_COUNTER_VALUE(3)) dut3 (
    .clock_i(clk), .reset_i(rst_s), .enable_i(en_s),
    .finished_o(fin3), .counter_val_o(val3)
  );

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (val !== 8'd0) begin
        failures++;
        $display("FAIL reset_val edge=%0d got=%0d exp=0", i, val);
      end
      checks++;
      if (fin !== 1'b0) begin
        failures++;
        $display("FAIL reset_fin edge=%0d got=%b exp=0", i, fin);
      end
    end
  endtask

  task automatic test_idle();
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (val !== 8'd0) begin
        failures++;
        $display("FAIL idle_val edge=%0d got=%0d exp=0", i, val);
      end
    end
  endtask

  task automatic test_count();
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (val !== 8'(i) || fin !== 1'b0) begin
        failures++;
        $display("FAIL count_step got=%0d/%b exp=%0d/0", val, fin, i);
      end
    end
  endtask

  task automatic test_hold();
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (val !== 8'd5) begin
        failures++;
        $display("FAIL hold_val edge=%0d got=%0d exp=5", i, val);
      end
    end
    en = 1'b1;
    for (int i = 6; i <= 7; i++) begin
      step();
      checks++;
      if (val !== 8'(i)) begin
        failures++;
        $display("FAIL resume_val got=%0d exp=%0d", val, i);
      end
    end
  endtask

  task automatic test_saturate();
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 160; i++) begin
      step();
      checks++;
      if (val !== 8'(i) || fin !== (i == 160)) begin
        failures++;
        $display("FAIL run_to_max edge=%0d got=%0d/%b exp=%0d/%b",
                 i, val, fin, i, (i == 160));
      end
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (val !== 8'd160 || fin !== 1'b1) begin
        failures++;
        $display("FAIL saturate_en got=%0d/%b exp=160/1", val, fin);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (val !== 8'd160 || fin !== 1'b1) begin
        failures++;
        $display("FAIL saturate_idle got=%0d/%b exp=160/1", val, fin);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 42; i++) step();
    checks++;
    if (val !== 8'd42) begin
      failures++;
      $display("FAIL mid_pre got=%0d exp=42", val);
    end
    rst = 1'b1;
    step();
    checks++;
    if (val !== 8'd0 || fin !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%0d/%b exp=0/0", val, fin);
    end
    rst = 1'b0;
    step();
    checks++;
    if (val !== 8'd1) begin
      failures++;
      $display("FAIL mid_resume got=%0d exp=1", val);
    end
  endtask

  task automatic test_small();
    rst_s = 1'b1; en_s = 1'b1;
    step();
    checks++;
    if (val1 !== 1'b0 || fin1 !== 1'b0 || val3 !== 2'd0 || fin3 !== 1'b0) begin
      failures++;
      $display("FAIL small_reset got=%b/%b %0d/%b exp=0/0 0/0",
               val1, fin1, val3, fin3);
    end
    rst_s = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++;
      if (val1 !== 1'b1 || fin1 !== 1'b1) begin
        failures++;
        $display("FAIL max1 edge=%0d got=%b/%b exp=1/1", i, val1, fin1);
      end
      checks++;
      if (val3 !== 2'((i < 3) ? i : 3) || fin3 !== (i >= 3)) begin
        failures++;
        $display("FAIL max3 edge=%0d got=%0d/%b exp=%0d/%b",
                 i, val3, fin3, (i < 3) ? i : 3, (i >= 3));
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rst_s = 1'b1; en_s = 1'b0;
    #1;
    test_reset();
    test_idle();
    test_count();
    test_hold();
    test_saturate();
    test_reset_mid();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
